clock_demux_4: RTL and testbench
================================

# clock_demux_4

Registered 1-to-4 demultiplexer with per-channel valid/acknowledge handshake: the write-side counterpart of the 4:1 selector used on the multicycle datapath. A producer presents one N-bit word plus a 2-bit channel select and a write strobe. The block latches the word into the selected output register, raises that channel's valid flag, and holds it until the consumer on that channel acknowledges. Writes to a channel still holding unacknowledged data are rejected and recorded in a sticky error flag.

## Interface
- N, 32, data width of the input word and of each output register.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk externally.
- S  in  N  input data word.
- Ctrl  in  2  destination channel select: 00→A, 01→B, 10→C, 11→D.
- We  in  1  write strobe; sampled at the rising edge of clk.
- Ack  in  4  per-channel acknowledge; bit0=A … bit3=D; level-sampled each cycle.
- Clr_err  in  1  clears Err and Err_ch.
- A, B, C, D  out  N  channel data registers.
- Valid  out  4  per-channel data-valid flags; bit order as Ack.
- Full  out  1  combinational AND of Valid[3:0].
- Err  out  1  sticky: a write was rejected.
- Err_ch  out  2  channel index of the first rejected write since the last clear.

## Operation
- **Reset (rst_n=0, asynchronous):**
  - A, B, C, D = 0; Valid = 4'b0000; Err = 0; Err_ch = 2'b00.
  - Full = 0.
- **Per-channel state.** Each channel i is a two-state machine:
  - EMPTY (Valid[i]=0): We with Ctrl=i loads S into the channel register and moves to HELD.
  - HELD (Valid[i]=1) with Ack[i]=1 and no write to i: moves to EMPTY. The data register keeps its value.
  - HELD with Ack[i]=0 and a write to i: the write is rejected. Register and Valid[i] are unchanged. Err is set.
  - HELD with Ack[i]=1 and a write to i in the same cycle: the acknowledge is honoured and the write is accepted. The register takes S and Valid[i] stays 1. Err is not set.
  - HELD with no Ack[i] and no write to i: holds.
- **Ack to an EMPTY channel:** ignored. No state change, no error.
- **Writes and acks are independent across channels.** One write (to a single channel) and up to four acks may occur in the same cycle.
- **Registers without a write:** only the selected channel's register can change. Non-selected registers and writes with We=0 never alter data.
- **Error capture:**
  - On a rejected write with Err=0: Err←1, Err_ch←Ctrl.
  - Further rejections while Err=1 leave Err_ch unchanged (first-error capture).
  - Clr_err=1 clears Err→0 and Err_ch→00 at the next edge.
  - Clr_err and a rejected write in the same cycle: the new error wins. Err=1 and Err_ch=Ctrl.
- **Ctrl when We=0:** don't-care.

## Timing
- **Write latency:** 1 cycle. S/Ctrl/We sampled at edge k; the data register and Valid are updated at edge k and visible after edge k.
- **Ack latency:** 1 cycle. Valid falls after the edge at which Ack is sampled high.
- **Full:** combinational from Valid, so it follows Valid with zero added latency.
- **Back-to-back writes:** one write per cycle to different channels is sustained indefinitely. To the same channel, one write per cycle is sustained only when the consumer asserts Ack every cycle.
- **Reset mid-operation:** all held data and flags are discarded immediately. Valid drops without waiting for Ack.
- **No combinational path from any input to A–D, Valid, Err or Err_ch.** The only combinational output is Full.

## Test plan
1. **Reset and first writes.** Assert rst_n=0 mid-cycle → all outputs 0 immediately. Release, then write We=1, Ctrl=10, S=32'hDEADBEEF → next cycle C=DEADBEEF, Valid=0100, and A, B, D stay 0.
2. **Fill all channels.** Write 1, 2, 3, 4 to channels A–D on consecutive cycles → Valid=1111 and Full=1. Then Ack=0001 → Valid=1110, Full=0, and A still reads 1.
3. **Rejected write.** Channel B is HELD with value 5. Write Ctrl=01, S=9 with Ack=0 → B stays 5, Err=1, Err_ch=01. Then write to D while D is HELD → Err_ch stays 01.
4. **Simultaneous ack and write.** Channel A is HELD with value 7. In the same cycle drive Ack[0]=1, We=1, Ctrl=00, S=8 → A=8, Valid[0]=1, Err=0.
5. **Error clear race.** Err=1, Err_ch=01. Drive Clr_err=1 alone → Err=0, Err_ch=00. Then drive Clr_err=1 together with a rejected write to channel C → Err=1, Err_ch=10.
6. **Reset mid-operation.** Valid=1011 with data loaded. Pulse rst_n low for 3 ns between edges → outputs zero asynchronously. A stale Ack on the first cycle after reset produces no change.

Source files
------------

// File: rtl/clock_demux_4.sv
// Registered 1-to-4 demultiplexer: latches S into the channel chosen by Ctrl,
// tracks per-channel valid/ack handshake and captures the first rejected write.
`timescale 1ns/1ps
module clock_demux_4 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] S,
  input  logic [1:0]   Ctrl,
  input  logic         We,
  input  logic [3:0]   Ack,
  input  logic         Clr_err,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic [N-1:0] D,
  output logic [3:0]   Valid,
  output logic         Full,
  output logic         Err,
  output logic [1:0]   Err_ch
);

  logic [N-1:0] data_q [4];
  logic [N-1:0] data_d [4];
  logic [3:0]   valid_q;
  logic [3:0]   valid_d;
  logic         err_q;
  logic         err_d;
  logic [1:0]   err_ch_q;
  logic [1:0]   err_ch_d;
  logic [3:0]   wr_sel_s;
  logic [3:0]   reject_s;

  // Write strobe decoded to a one-hot channel select
  always_comb begin
    wr_sel_s = 4'b0000;
    if (We) begin
      case (Ctrl)
        2'b00:   wr_sel_s = 4'b0001;
        2'b01:   wr_sel_s = 4'b0010;
        2'b10:   wr_sel_s = 4'b0100;
        2'b11:   wr_sel_s = 4'b1000;
        default: wr_sel_s = 4'b0000;
      endcase
    end else begin
      wr_sel_s = 4'b0000;
    end
  end

  // Per-channel EMPTY/HELD machine; an ack in the write cycle frees the slot for it
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data_d[i]   = data_q[i];
      valid_d[i]  = valid_q[i];
      reject_s[i] = 1'b0;
      if (wr_sel_s[i] && (!valid_q[i] || Ack[i])) begin
        data_d[i]  = S;
        valid_d[i] = 1'b1;
      end else if (wr_sel_s[i]) begin
        reject_s[i] = 1'b1;
      end else if (valid_q[i] && Ack[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // First-error capture; a fresh rejection beats a simultaneous clear
  always_comb begin
    err_d    = err_q;
    err_ch_d = err_ch_q;
    if ((|reject_s) && (!err_q || Clr_err)) begin
      err_d    = 1'b1;
      err_ch_d = Ctrl;
    end else if (Clr_err) begin
      err_d    = 1'b0;
      err_ch_d = 2'b00;
    end else begin
      err_d    = err_q;
      err_ch_d = err_ch_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= {N{1'b0}};
      end
      valid_q  <= 4'b0000;
      err_q    <= 1'b0;
      err_ch_q <= 2'b00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q  <= valid_d;
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
    end
  end

  assign A      = data_q[0];
  assign B      = data_q[1];
  assign C      = data_q[2];
  assign D      = data_q[3];
  assign Valid  = valid_q;
  assign Full   = &valid_q;
  assign Err    = err_q;
  assign Err_ch = err_ch_q;

endmodule

// File: tb/tb_clock_demux_4.sv
// Table-driven bench for clock_demux_4 with a queue scoreboard of expected outputs.
`timescale 1ns/1ps
module tb_clock_demux_4;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] s;
  logic [1:0]   ctrl;
  logic         we;
  logic [3:0]   ack;
  logic         clr_err;
  logic [N-1:0] a, b, c, d;
  logic [3:0]   valid;
  logic         full;
  logic         err;
  logic [1:0]   err_ch;

  clock_demux_4 #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .S(s), .Ctrl(ctrl), .We(we), .Ack(ack), .Clr_err(clr_err),
    .A(a), .B(b), .C(c), .D(d), .Valid(valid), .Full(full), .Err(err), .Err_ch(err_ch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [3:0]  valid;
    logic        full;
    logic        err;
    logic [1:0]  err_ch;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  ctrl;
    logic [31:0] s;
    logic [3:0]  ack;
    logic        clr;
    exp_t        e;
  } vec_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  vec_t  vecs[21];

  function automatic exp_t mke(logic [31:0] ea, logic [31:0] eb, logic [31:0] ec, logic [31:0] ed,
                               logic [3:0] ev, logic ee, logic [1:0] ech);
    exp_t e;
    e.a = ea; e.b = eb; e.c = ec; e.d = ed;
    e.valid = ev; e.full = &ev; e.err = ee; e.err_ch = ech;
    return e;
  endfunction

  function automatic vec_t mkv(logic w, logic [1:0] ct, logic [31:0] sv, logic [3:0] ak, logic cl, exp_t e);
    vec_t v;
    v.we = w; v.ctrl = ct; v.s = sv; v.ack = ak; v.clr = cl; v.e = e;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp({t, ".A"}, a, e.a);
    cmp({t, ".B"}, b, e.b);
    cmp({t, ".C"}, c, e.c);
    cmp({t, ".D"}, d, e.d);
    cmp({t, ".Valid"}, 32'(valid), 32'(e.valid));
    cmp({t, ".Full"}, 32'(full), 32'(e.full));
    cmp({t, ".Err"}, 32'(err), 32'(e.err));
    cmp({t, ".Err_ch"}, 32'(err_ch), 32'(e.err_ch));
  endtask

  task automatic expect_now(string t, exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    pop_check();
  endtask

  task automatic step(logic w, logic [1:0] ct, logic [31:0] sv, logic [3:0] ak, logic cl, exp_t e, string t);
    @(negedge clk);
    we = w; ctrl = ct; s = sv; ack = ak; clr_err = cl;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    pop_check();
    we = 1'b0; ack = 4'b0000; clr_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mkv(1'b1, 2'b10, 32'hDEADBEEF, 4'b0000, 1'b0, mke(32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 4'b0100, 1'b0, 2'b00));
    vecs[1]  = mkv(1'b0, 2'b00, 32'd0, 4'b0100, 1'b0, mke(32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 4'b0000, 1'b0, 2'b00));
    vecs[2]  = mkv(1'b1, 2'b00, 32'd1, 4'b0000, 1'b0, mke(32'd1, 32'd0, 32'hDEADBEEF, 32'd0, 4'b0001, 1'b0, 2'b00));
    vecs[3]  = mkv(1'b1, 2'b01, 32'd2, 4'b0000, 1'b0, mke(32'd1, 32'd2, 32'hDEADBEEF, 32'd0, 4'b0011, 1'b0, 2'b00));
    vecs[4]  = mkv(1'b1, 2'b10, 32'd3, 4'b0000, 1'b0, mke(32'd1, 32'd2, 32'd3, 32'd0, 4'b0111, 1'b0, 2'b00));
    vecs[5]  = mkv(1'b1, 2'b11, 32'd4, 4'b0000, 1'b0, mke(32'd1, 32'd2, 32'd3, 32'd4, 4'b1111, 1'b0, 2'b00));
    vecs[6]  = mkv(1'b0, 2'b00, 32'd0, 4'b0001, 1'b0, mke(32'd1, 32'd2, 32'd3, 32'd4, 4'b1110, 1'b0, 2'b00));
    vecs[7]  = mkv(1'b0, 2'b00, 32'd0, 4'b0001, 1'b0, mke(32'd1, 32'd2, 32'd3, 32'd4, 4'b1110, 1'b0, 2'b00));
    vecs[8]  = mkv(1'b0, 2'b00, 32'd0, 4'b0010, 1'b0, mke(32'd1, 32'd2, 32'd3, 32'd4, 4'b1100, 1'b0, 2'b00));
    vecs[9]  = mkv(1'b1, 2'b01, 32'd5, 4'b0000, 1'b0, mke(32'd1, 32'd5, 32'd3, 32'd4, 4'b1110, 1'b0, 2'b00));
    vecs[10] = mkv(1'b1, 2'b01, 32'd9, 4'b0000, 1'b0, mke(32'd1, 32'd5, 32'd3, 32'd4, 4'b1110, 1'b1, 2'b01));
    vecs[11] = mkv(1'b1, 2'b11, 32'hAA, 4'b0000, 1'b0, mke(32'd1, 32'd5, 32'd3, 32'd4, 4'b1110, 1'b1, 2'b01));
    vecs[12] = mkv(1'b0, 2'b01, 32'hFFFFFFFF, 4'b0000, 1'b0, mke(32'd1, 32'd5, 32'd3, 32'd4, 4'b1110, 1'b1, 2'b01));
    vecs[13] = mkv(1'b0, 2'b00, 32'd0, 4'b0000, 1'b1, mke(32'd1, 32'd5, 32'd3, 32'd4, 4'b1110, 1'b0, 2'b00));
    vecs[14] = mkv(1'b1, 2'b00, 32'd7, 4'b0000, 1'b0, mke(32'd7, 32'd5, 32'd3, 32'd4, 4'b1111, 1'b0, 2'b00));
    vecs[15] = mkv(1'b1, 2'b00, 32'd8, 4'b0001, 1'b0, mke(32'd8, 32'd5, 32'd3, 32'd4, 4'b1111, 1'b0, 2'b00));
    vecs[16] = mkv(1'b1, 2'b10, 32'h55, 4'b0000, 1'b1, mke(32'd8, 32'd5, 32'd3, 32'd4, 4'b1111, 1'b1, 2'b10));
    vecs[17] = mkv(1'b1, 2'b11, 32'h66, 4'b1111, 1'b0, mke(32'd8, 32'd5, 32'd3, 32'h66, 4'b1000, 1'b1, 2'b10));
    vecs[18] = mkv(1'b1, 2'b11, 32'h77, 4'b0000, 1'b1, mke(32'd8, 32'd5, 32'd3, 32'h66, 4'b1000, 1'b1, 2'b11));
    vecs[19] = mkv(1'b1, 2'b00, 32'h11, 4'b0000, 1'b0, mke(32'h11, 32'd5, 32'd3, 32'h66, 4'b1001, 1'b1, 2'b11));
    vecs[20] = mkv(1'b1, 2'b01, 32'h22, 4'b0000, 1'b0, mke(32'h11, 32'h22, 32'd3, 32'h66, 4'b1011, 1'b1, 2'b11));

    rst_n = 1'b0; we = 1'b0; ctrl = 2'b00; s = 32'd0; ack = 4'b0000; clr_err = 1'b0;
    #12;
    expect_now("reset", mke(32'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].we, vecs[i].ctrl, vecs[i].s, vecs[i].ack, vecs[i].clr, vecs[i].e, $sformatf("v%0d", i));
    end

    // Asynchronous reset pulse between edges while Valid=1011
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("mid_reset", mke(32'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b0, 2'b00));
    #2;
    rst_n = 1'b1;
    step(1'b0, 2'b00, 32'd0, 4'b1111, 1'b0, mke(32'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b0, 2'b00), "stale_ack");
    step(1'b1, 2'b01, 32'h12345678, 4'b0000, 1'b0,
         mke(32'd0, 32'h12345678, 32'd0, 32'd0, 4'b0010, 1'b0, 2'b00), "post_reset_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
